clk_div_multi: RTL and testbench

- Multi-channel, runtime-programmable integer clock divider for the PWM demo fabric; next generation of the fixed even-ratio divider.
- NUM_CH independent channels share one input clock.
- Each channel has a divisor written over a simple write port. The divisor accepts odd or even values and is applied glitch-free at that channel's period boundary.
- Provides a divided square wave, a one-cycle period tick per channel, and a global resynchronisation input for phase-aligning channels.

---
 rtl/clk_div_multi.sv | 61 ++++++
 tb/tb_clk_div_multi.sv | 131 +++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel runtime-programmable integer clock divider
// Divisor changes take effect only at a channel's period boundary or on sync.
module clk_div_multi #(
  parameter int NUM_CH = 4,
  parameter int DIV_W = 16,
  parameter int DEFAULT_DIV = 10,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in_i,
  input  logic              rst_n_i,
  input  logic              sync_i,
  input  logic              wr_en_i,
  input  logic [CH_W-1:0]   wr_ch_i,
  input  logic [DIV_W-1:0]  wr_div_i,
  output logic [NUM_CH-1:0] clk_out_o,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] pend_o
);
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO = DIV_W'(2);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DIV_W-1:0] div_q, cnt_q, pdiv_q, div_b, div_n, cnt_n, pdiv_n;
    logic pend_q, pend_n, clk_q, tick_q, clk_n, tick_n, wrap, restart, hit, en_b, en_n;
    // Out-of-range channel indices never match any c, so such writes are dropped.
    always_comb begin
      wrap = div_q >= TWO && cnt_q == div_q - ONE;
      restart = sync_i || wrap;
      hit = wr_en_i && wr_ch_i == CH_W'(c);
      div_b = restart && pend_q ? pdiv_q : div_q;
      en_b = div_b >= TWO;
      cnt_n = restart || div_q < TWO ? '0 : cnt_q + ONE;
      div_n = hit && !en_b ? wr_div_i : div_b;
      pdiv_n = hit && en_b ? wr_div_i : pdiv_q;
      pend_n = (pend_q && !restart) || (hit && en_b);
      en_n = div_n >= TWO;
      clk_n = en_n && cnt_n >= (div_n >> 1) + DIV_W'(div_n[0]);
      tick_n = en_n && cnt_n == div_n - ONE;
    end
    // Outputs are registered from the next state so they line up with cnt.
    always_ff @(posedge clk_in_i) begin
      if (!rst_n_i) begin
        div_q <= DIV_W'(DEFAULT_DIV);
        cnt_q <= '0;
        pdiv_q <= '0;
        pend_q <= 1'b0;
        clk_q <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        div_q <= div_n;
        cnt_q <= cnt_n;
        pdiv_q <= pdiv_n;
        pend_q <= pend_n;
        clk_q <= clk_n;
        tick_q <= tick_n;
      end
    end
    assign clk_out_o[c] = clk_q;
    assign tick_o[c] = tick_q;
    assign pend_o[c] = pend_q;
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: scoreboard bench for clk_div_multi against a cycle-position model
module tb_clk_div_multi;
  localparam int N = 5;
  localparam int W = 6;
  localparam int DEF = 10;
  logic clk = 1'b0;
  logic rst_n = 1'b0, sync = 1'b0, wr_en = 1'b0;
  logic [2:0] wr_ch = '0;
  logic [W-1:0] wr_div = '0;
  logic [N-1:0] clk_out, tick, pend;
  int md[N], mpos[N], mp[N];
  bit mpend[N];
  logic [3*N-1:0] expq[$];
  int ncmp = 0, nfail = 0, ncyc = 0;

  clk_div_multi #(.NUM_CH(N), .DIV_W(W), .DEFAULT_DIV(DEF)) dut (
    .clk_in_i(clk), .rst_n_i(rst_n), .sync_i(sync), .wr_en_i(wr_en),
    .wr_ch_i(wr_ch), .wr_div_i(wr_div),
    .clk_out_o(clk_out), .tick_o(tick), .pend_o(pend)
  );

  always #5 clk = ~clk;

  task automatic cyc(input bit r, input bit s, input bit we, input int ch, input int dv);
    logic [N-1:0] ec, et, ep;
    rst_n = r; sync = s; wr_en = we; wr_ch = 3'(ch); wr_div = W'(dv);
    for (int c = 0; c < N; c++) begin
      if (!r) begin
        md[c] = DEF; mpos[c] = 0; mpend[c] = 0;
      end else begin
        if (s || (md[c] >= 2 && mpos[c] == md[c] - 1)) begin
          if (mpend[c]) md[c] = mp[c];
          mpend[c] = 0; mpos[c] = 0;
        end else if (md[c] >= 2) mpos[c]++;
        else mpos[c] = 0;
        if (we && ch == c) begin
          if (md[c] >= 2) begin mp[c] = dv; mpend[c] = 1; end
          else begin md[c] = dv; mpos[c] = 0; end
        end
      end
      ec[c] = md[c] >= 2 && mpos[c] >= (md[c] + 1) / 2;
      et[c] = md[c] >= 2 && mpos[c] == md[c] - 1;
      ep[c] = mpend[c];
    end
    expq.push_back({ec, et, ep});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
  endtask

  task automatic wr(input int ch, input int dv);
    cyc(1, 0, 1, ch, dv);
  endtask

  initial forever begin
    logic [3*N-1:0] e, g;
    @(negedge clk);
    if (expq.size() > 0) begin
      e = expq.pop_front();
      g = {clk_out, tick, pend};
      ncyc++;
      ncmp += 3;
      if (g[3*N-1:2*N] !== e[3*N-1:2*N]) begin
        nfail++;
        $display("FAIL clk_out cyc=%0d got=%b exp=%b", ncyc, g[3*N-1:2*N], e[3*N-1:2*N]);
      end
      if (g[2*N-1:N] !== e[2*N-1:N]) begin
        nfail++;
        $display("FAIL tick cyc=%0d got=%b exp=%b", ncyc, g[2*N-1:N], e[2*N-1:N]);
      end
      if (g[N-1:0] !== e[N-1:0]) begin
        nfail++;
        $display("FAIL pend cyc=%0d got=%b exp=%b", ncyc, g[N-1:0], e[N-1:0]);
      end
    end
  end

  initial begin
    int r;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    idle(3);
    wr(1, 7);
    idle(30);
    wr(2, 4);
    idle(1);
    wr(2, 6);
    idle(25);
    wr(3, 0);
    idle(20);
    wr(3, 3);
    idle(12);
    wr(0, 4);
    wr(1, 6);
    idle(13);
    cyc(1, 1, 0, 0, 0);
    idle(30);
    wr(5, 2);
    wr(7, 1);
    idle(6);
    wr(4, 63);
    idle(140);
    wr(1, 9);
    idle(2);
    cyc(0, 0, 0, 0, 0);
    idle(35);
    wr(2, 1);
    idle(12);
    cyc(1, 1, 1, 2, 5);
    cyc(1, 1, 1, 0, 3);
    cyc(1, 1, 0, 0, 0);
    idle(10);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      cyc($urandom_range(0, 199) != 0, $urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 7),
          r < 1 ? 63 : r < 3 ? $urandom_range(0, 1) : $urandom_range(2, 12));
    end
    repeat (3) @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      nfail++;
      $display("FAIL drain left=%0d exp=0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
